// File: rtl/ifetch.sv
// Instruction fetch front end: one outstanding imem request at a time, a
// 2-entry {pc, instr} buffer toward decode, and redirect/drop handling.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // nothing outstanding
    WAIT = 2'd1,  // one request outstanding, result will be kept
    DROP = 2'd2   // one request outstanding, result is stale
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  logic [31:0] fifo_pc   [2];
  logic [31:0] fifo_data [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;
  logic        push, pop;

  // Issuing only with a free slot guarantees the eventual push never overflows.
  assign imem_req    = (state == IDLE) && (count < 2'd2) && !redirect_valid;
  assign imem_addr   = fetch_pc;
  assign instr_valid = (count != 2'd0);
  assign instr       = fifo_data[rd_ptr];
  assign instr_pc    = fifo_pc[rd_ptr];
  assign pop         = instr_valid && instr_ready;
  assign push        = (state == WAIT) && imem_rvalid && !redirect_valid;

  // NOTE: next-state is defaulted to the current state before the case so no
  // path through the block leaves state_nxt unassigned (which would infer a latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (imem_req) state_nxt = WAIT;
      WAIT, DROP: begin
        // A response retires the outstanding request even when a redirect
        // arrives in the same cycle; otherwise a redirect makes it stale.
        if (imem_rvalid)         state_nxt = IDLE;
        else if (redirect_valid) state_nxt = DROP;
      end
      default:    state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the two buffer entries are reset as well, because instr/instr_pc
  // are driven straight from the head entry and must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc     <= RESET_PC;
      req_pc       <= 32'h0;
      count        <= 2'd0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      misalign_err <= 1'b0;
      fifo_pc[0]   <= 32'h0;
      fifo_pc[1]   <= 32'h0;
      fifo_data[0] <= 32'h0;
      fifo_data[1] <= 32'h0;
    end else begin
      misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (redirect_valid) begin
        // A pop in this cycle is consumed downstream; everything else is flushed.
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        count    <= 2'd0;
        rd_ptr   <= 1'b0;
        wr_ptr   <= 1'b0;
      end else begin
        if (imem_req) begin
          fetch_pc <= fetch_pc + 32'd4;
          req_pc   <= fetch_pc;
        end
        if (push) begin
          fifo_pc[wr_ptr]   <= req_pc;
          fifo_data[wr_ptr] <= imem_rdata;
          wr_ptr            <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

endmodule
